// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache arbiter: word/line/mask widths, the arbiter
// FSM state encoding and the one-bit requester select.
package cache_arbiter_pkg;

    localparam int DATA_WIDTH = 128;
    localparam int ADDR_WIDTH = 16;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef logic [ADDR_WIDTH-1:0] lc3b_word;
    typedef logic [DATA_WIDTH-1:0] lc3b_data;
    typedef logic [MASK_WIDTH-1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2,
        ARB_DRAIN   = 2'd3
    } lc3b_arb_state;

    // 0 selects the I-side (fetch), 1 selects the D-side (memory stage)
    typedef enum logic {
        ARB_SEL_I = 1'b0,
        ARB_SEL_D = 1'b1
    } lc3b_arb_sel;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared lower
// memory port.
//   i_*   : I-side read-only requester (stb/cyc/address in, rdata/resp/retry out)
//   d_*   : D-side requester (stb/cyc/write/address/wdata/byte_enable in,
//           rdata/resp/retry out)
//   mem_* : lower port (stb/cyc/write/address/wdata/byte_enable out,
//           rdata/resp/retry in)
// slave  = arbiter view, master = requester/memory environment view.
interface cache_arbiter_if;
    import cache_arbiter_pkg::*;

    logic          i_stb;
    logic          i_cyc;
    lc3b_word      i_address;
    lc3b_data      i_rdata;
    logic          i_resp;
    logic          i_retry;

    logic          d_stb;
    logic          d_cyc;
    logic          d_write;
    lc3b_word      d_address;
    lc3b_data      d_wdata;
    lc3b_mem_wmask d_byte_enable;
    lc3b_data      d_rdata;
    logic          d_resp;
    logic          d_retry;

    logic          mem_stb;
    logic          mem_cyc;
    logic          mem_write;
    lc3b_word      mem_address;
    lc3b_data      mem_wdata;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_data      mem_rdata;
    logic          mem_resp;
    logic          mem_retry;

    modport slave (
        input  i_stb, i_cyc, i_address,
        output i_rdata, i_resp, i_retry,
        input  d_stb, d_cyc, d_write, d_address, d_wdata, d_byte_enable,
        output d_rdata, d_resp, d_retry,
        output mem_stb, mem_cyc, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp, mem_retry
    );

    modport master (
        output i_stb, i_cyc, i_address,
        input  i_rdata, i_resp, i_retry,
        output d_stb, d_cyc, d_write, d_address, d_wdata, d_byte_enable,
        input  d_rdata, d_resp, d_retry,
        input  mem_stb, mem_cyc, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp, mem_retry
    );

endinterface

// File: rtl/cache_arbiter_port_mux.sv
// Combinational field select for the lower memory port.
//   active          : drive the selected requester's fields (else all zero)
//   sel             : requester whose fields go out (I or D)
//   i_address       : I-side address
//   d_write/d_address/d_wdata/d_byte_enable : D-side request fields
//   mem_write/mem_address/mem_wdata/mem_byte_enable : lower-port fields
// The I-side is read-only, so its write enable, write data and mask are zero.
module cache_arbiter_port_mux
    import cache_arbiter_pkg::*;
(
    input  logic          active,
    input  lc3b_arb_sel   sel,
    input  lc3b_word      i_address,
    input  logic          d_write,
    input  lc3b_word      d_address,
    input  lc3b_data      d_wdata,
    input  lc3b_mem_wmask d_byte_enable,
    output logic          mem_write,
    output lc3b_word      mem_address,
    output lc3b_data      mem_wdata,
    output lc3b_mem_wmask mem_byte_enable
);

    always_comb begin
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        if (active) begin
            if (sel == ARB_SEL_D) begin
                mem_write       = d_write;
                mem_address     = d_address;
                mem_wdata       = d_wdata;
                mem_byte_enable = d_byte_enable;
            end else begin
                mem_address     = i_address;
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one lower memory port between the I-side
// (fetch) and D-side (memory stage) requesters, one transaction at a time.
//   clk   : system clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : requester and lower-port signals (see cache_arbiter_if)
// Responses and retries reach only the granted requester; a requester that is
// not granted sees retry = its own cyc. If the granted requester abandons its
// cycle, the outstanding memory response is drained and discarded.
module cache_arbiter
    import cache_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    cache_arbiter_if.slave  bus
);

    lc3b_arb_state state;
    lc3b_arb_state state_next;
    lc3b_arb_sel   last_grant;
    lc3b_arb_sel   owner;
    lc3b_arb_sel   owner_next;
    logic          i_pend;
    logic          d_pend;
    logic          mux_active;

    assign i_pend = bus.i_stb & bus.i_cyc;
    assign d_pend = bus.d_stb & bus.d_cyc;

    // last_grant moves only on a delivered response; a drained transaction
    // does not count as a turn. owner remembers the side whose fields stay
    // on the port while draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= ARB_SEL_I;
            owner      <= ARB_SEL_I;
        end else begin
            state <= state_next;
            owner <= owner_next;
            if (state == ARB_GRANT_I && bus.mem_resp) begin
                last_grant <= ARB_SEL_I;
            end else if (state == ARB_GRANT_D && bus.mem_resp) begin
                last_grant <= ARB_SEL_D;
            end
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            ARB_IDLE: begin
                // On a tie the side that did not win last time goes first
                if (i_pend && (!d_pend || last_grant == ARB_SEL_D)) begin
                    state_next = ARB_GRANT_I;
                    owner_next = ARB_SEL_I;
                end else if (d_pend) begin
                    state_next = ARB_GRANT_D;
                    owner_next = ARB_SEL_D;
                end
            end
            // A response in the same cycle as a cyc drop still completes
            ARB_GRANT_I: begin
                if (bus.mem_resp) begin
                    state_next = ARB_IDLE;
                end else if (!bus.i_cyc) begin
                    state_next = ARB_DRAIN;
                end
            end
            ARB_GRANT_D: begin
                if (bus.mem_resp) begin
                    state_next = ARB_IDLE;
                end else if (!bus.d_cyc) begin
                    state_next = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (bus.mem_resp) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        mux_active  = 1'b0;
        bus.mem_stb = 1'b0;
        bus.mem_cyc = 1'b0;
        bus.i_resp  = 1'b0;
        bus.d_resp  = 1'b0;
        bus.i_retry = bus.i_cyc;
        bus.d_retry = bus.d_cyc;
        bus.i_rdata = '0;
        bus.d_rdata = '0;
        case (state)
            ARB_GRANT_I: begin
                mux_active  = 1'b1;
                bus.mem_stb = 1'b1;
                bus.mem_cyc = 1'b1;
                bus.i_resp  = bus.mem_resp;
                bus.i_retry = bus.mem_retry;
                bus.i_rdata = bus.mem_resp ? bus.mem_rdata : '0;
            end
            ARB_GRANT_D: begin
                mux_active  = 1'b1;
                bus.mem_stb = 1'b1;
                bus.mem_cyc = 1'b1;
                bus.d_resp  = bus.mem_resp;
                bus.d_retry = bus.mem_retry;
                bus.d_rdata = bus.mem_resp ? bus.mem_rdata : '0;
            end
            ARB_DRAIN: begin
                mux_active  = 1'b1;
                bus.mem_cyc = 1'b1;
            end
            default: ;
        endcase
        // Nothing leaks out while reset is held, including a response that
        // arrives in the reset cycle itself.
        if (reset) begin
            mux_active  = 1'b0;
            bus.mem_stb = 1'b0;
            bus.mem_cyc = 1'b0;
            bus.i_resp  = 1'b0;
            bus.d_resp  = 1'b0;
            bus.i_retry = 1'b0;
            bus.d_retry = 1'b0;
            bus.i_rdata = '0;
            bus.d_rdata = '0;
        end
    end

    cache_arbiter_port_mux u_port_mux (
        .active          (mux_active),
        .sel             (owner),
        .i_address       (bus.i_address),
        .d_write         (bus.d_write),
        .d_address       (bus.d_address),
        .d_wdata         (bus.d_wdata),
        .d_byte_enable   (bus.d_byte_enable),
        .mem_write       (bus.mem_write),
        .mem_address     (bus.mem_address),
        .mem_wdata       (bus.mem_wdata),
        .mem_byte_enable (bus.mem_byte_enable)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: lower-port responses are driven from the
// stimulus sequence; each response is queued with its expected destination
// and data, then popped when the requester-side response is checked.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cache_arbiter_if bus();

    cache_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic     side;
        lc3b_data rdata;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp();
        sb_t e;
        chk16("sb_depth", 16'(sb_q.size()), 16'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk1("i_resp", bus.i_resp, e.side == 1'b0);
            chk1("d_resp", bus.d_resp, e.side == 1'b1);
            chk128("rdata", e.side ? bus.d_rdata : bus.i_rdata, e.rdata);
        end
    endtask

    // Entered in the first granted cycle; holds wait_cyc cycles (the first
    // nretry of them with mem_retry), then responds with rd and steps one edge.
    task automatic serve(input logic side, input logic [15:0] addr, input lc3b_data rd,
                         input int wait_cyc, input int nretry);
        sb_t e;
        e.side  = side;
        e.rdata = rd;
        sb_q.push_back(e);
        for (int k = 0; k < wait_cyc; k++) begin
            bus.mem_retry = (k < nretry);
            #1;
            chk1("hold_stb", bus.mem_stb, 1'b1);
            chk16("hold_addr", bus.mem_address, addr);
            chk1("own_retry", side ? bus.d_retry : bus.i_retry, k < nretry);
            chk1("other_retry", side ? bus.i_retry : bus.d_retry, side ? bus.i_cyc : bus.d_cyc);
            chk1("early_resp", bus.i_resp | bus.d_resp, 1'b0);
            tick();
        end
        bus.mem_retry = 1'b0;
        bus.mem_rdata = rd;
        bus.mem_resp  = 1'b1;
        #1;
        check_resp();
        tick();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        reset = 1'b1;
        bus.i_stb = 1'b0; bus.i_cyc = 1'b0; bus.i_address = '0;
        bus.d_stb = 1'b0; bus.d_cyc = 1'b1; bus.d_write = 1'b0;
        bus.d_address = '0; bus.d_wdata = '0; bus.d_byte_enable = '0;
        bus.mem_rdata = '0; bus.mem_resp = 1'b0; bus.mem_retry = 1'b0;
        tick();
        tick();
        chk1("rst_mem_stb", bus.mem_stb, 1'b0);
        chk1("rst_mem_cyc", bus.mem_cyc, 1'b0);
        chk1("rst_mem_write", bus.mem_write, 1'b0);
        chk16("rst_mem_addr", bus.mem_address, 16'h0);
        chk1("rst_i_resp", bus.i_resp, 1'b0);
        chk1("rst_d_resp", bus.d_resp, 1'b0);
        chk1("rst_i_retry", bus.i_retry, 1'b0);
        chk1("rst_d_retry", bus.d_retry, 1'b0);
        chk128("rst_i_rdata", bus.i_rdata, '0);
        chk128("rst_d_rdata", bus.d_rdata, '0);

        // I-only read
        reset = 1'b0;
        bus.d_cyc = 1'b0;
        bus.i_stb = 1'b1; bus.i_cyc = 1'b1; bus.i_address = 16'h0040;
        #1;
        chk1("t1_idle_stb", bus.mem_stb, 1'b0);
        chk1("t1_idle_iretry", bus.i_retry, 1'b1);
        tick();
        chk1("t1_grant_stb", bus.mem_stb, 1'b1);
        chk1("t1_grant_cyc", bus.mem_cyc, 1'b1);
        chk1("t1_grant_write", bus.mem_write, 1'b0);
        chk16("t1_grant_mask", bus.mem_byte_enable, 16'h0);
        chk16("t1_grant_addr", bus.mem_address, 16'h0040);
        serve(1'b0, 16'h0040, {16{8'hA5}}, 3, 0);
        bus.i_stb = 1'b0; bus.i_cyc = 1'b0;
        #1;
        chk1("t1_resp_once", bus.i_resp, 1'b0);
        chk1("t1_no_dresp", bus.d_resp, 1'b0);
        chk1("t1_back_idle", bus.mem_stb, 1'b0);

        // Both pending out of reset: D first
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.i_stb = 1'b1; bus.i_cyc = 1'b1; bus.i_address = 16'h0040;
        bus.d_stb = 1'b1; bus.d_cyc = 1'b1; bus.d_write = 1'b1; bus.d_address = 16'h0080;
        bus.d_wdata = {4{32'hDEAD_BEEF}}; bus.d_byte_enable = 16'hFFFF;
        #1;
        chk1("t2_idle_iretry", bus.i_retry, 1'b1);
        chk1("t2_idle_dretry", bus.d_retry, 1'b1);
        tick();
        chk16("t2_d_addr", bus.mem_address, 16'h0080);
        chk1("t2_d_write", bus.mem_write, 1'b1);
        chk16("t2_d_mask", bus.mem_byte_enable, 16'hFFFF);
        chk128("t2_d_wdata", bus.mem_wdata, {4{32'hDEAD_BEEF}});
        serve(1'b1, 16'h0080, {8{16'h1234}}, 2, 0);
        bus.d_stb = 1'b0; bus.d_cyc = 1'b0; bus.d_write = 1'b0; bus.d_byte_enable = '0;
        #1;
        chk1("t2_gap_stb", bus.mem_stb, 1'b0);
        chk1("t2_gap_iretry", bus.i_retry, 1'b1);
        tick();
        chk1("t2_i_stb", bus.mem_stb, 1'b1);
        chk16("t2_i_addr", bus.mem_address, 16'h0040);
        chk1("t2_i_write", bus.mem_write, 1'b0);
        serve(1'b0, 16'h0040, {8{16'h5678}}, 1, 0);

        // Continuous requests from both sides alternate D,I,D,I,D,I
        bus.d_stb = 1'b1; bus.d_cyc = 1'b1; bus.d_address = 16'h0080;
        for (int t = 0; t < 6; t++) begin
            logic side;
            logic [15:0] addr;
            side = (t % 2 == 0);
            addr = side ? 16'h0080 : 16'h0040;
            #1;
            chk1("t3_idle_stb", bus.mem_stb, 1'b0);
            tick();
            chk16("t3_alt_addr", bus.mem_address, addr);
            serve(side, addr, {4{32'hC0DE_0000 + 32'(t)}}, 1 + (t % 2), 0);
        end

        // mem_retry held 4 cycles during GRANT_I
        bus.d_stb = 1'b0; bus.d_cyc = 1'b0;
        #1;
        tick();
        chk16("t4_grant_addr", bus.mem_address, 16'h0040);
        serve(1'b0, 16'h0040, {2{64'h0123_4567_89AB_CDEF}}, 5, 4);
        bus.i_stb = 1'b0; bus.i_cyc = 1'b0;

        // D abandons its cycle: drain and discard
        bus.d_stb = 1'b1; bus.d_cyc = 1'b1; bus.d_address = 16'h0100;
        #1;
        tick();
        chk1("t5_grant_stb", bus.mem_stb, 1'b1);
        tick();
        bus.d_stb = 1'b0; bus.d_cyc = 1'b0;
        #1;
        chk1("t5_drop_dresp", bus.d_resp, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk1("t5_drain_stb", bus.mem_stb, 1'b0);
            chk1("t5_drain_cyc", bus.mem_cyc, 1'b1);
            chk16("t5_drain_addr", bus.mem_address, 16'h0100);
            chk1("t5_drain_dresp", bus.d_resp, 1'b0);
        end
        bus.mem_resp = 1'b1; bus.mem_rdata = {4{32'hBAD0_BAD0}};
        #1;
        chk1("t5_discard_dresp", bus.d_resp, 1'b0);
        chk1("t5_discard_iresp", bus.i_resp, 1'b0);
        chk1("t5_discard_cyc", bus.mem_cyc, 1'b1);
        tick();
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        #1;
        chk1("t5_idle_cyc", bus.mem_cyc, 1'b0);

        // Response and cyc drop together still complete
        bus.d_stb = 1'b1; bus.d_cyc = 1'b1; bus.d_address = 16'h0200;
        #1;
        tick();
        chk1("t5b_grant_stb", bus.mem_stb, 1'b1);
        begin
            sb_t e;
            e.side = 1'b1;
            e.rdata = {4{32'h5A5A_0200}};
            sb_q.push_back(e);
        end
        bus.d_stb = 1'b0; bus.d_cyc = 1'b0;
        bus.mem_resp = 1'b1; bus.mem_rdata = {4{32'h5A5A_0200}};
        #1;
        check_resp();
        tick();
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        #1;
        chk1("t5b_idle_cyc", bus.mem_cyc, 1'b0);
        tick();
        chk1("t5b_still_idle", bus.mem_cyc, 1'b0);

        // Reset during GRANT_D, late response ignored
        bus.d_stb = 1'b1; bus.d_cyc = 1'b1; bus.d_write = 1'b1;
        bus.d_address = 16'h0300; bus.d_byte_enable = 16'h00FF;
        #1;
        tick();
        chk1("t6_grant_stb", bus.mem_stb, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.d_stb = 1'b0; bus.d_cyc = 1'b0; bus.d_write = 1'b0; bus.d_byte_enable = '0;
        bus.mem_resp = 1'b1; bus.mem_rdata = {4{32'hFEED_0300}};
        #1;
        chk1("t6_mem_stb", bus.mem_stb, 1'b0);
        chk1("t6_mem_cyc", bus.mem_cyc, 1'b0);
        chk1("t6_mem_write", bus.mem_write, 1'b0);
        chk16("t6_mem_addr", bus.mem_address, 16'h0);
        chk16("t6_mem_mask", bus.mem_byte_enable, 16'h0);
        chk1("t6_late_dresp", bus.d_resp, 1'b0);
        chk128("t6_late_drdata", bus.d_rdata, '0);
        tick();
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        #1;
        chk1("t6_idle_cyc", bus.mem_cyc, 1'b0);
        chk1("t6_idle_dresp", bus.d_resp, 1'b0);

        chk16("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
